rank_window_ctrl: RTL and testbench

Sequencer for the window shift registers and line buffers that feed the masked rank-order filter. Accepts a raster pixel stream with a valid/ready handshake and produces a single shift enable for the whole window datapath. Tracks row and column positions, flags each cycle where the N×N window holds a complete interior neighbourhood, and stalls the input when the downstream sorter applies backpressure.

---
 rtl/rank_window_ctrl_if.sv | 60 ++++++
 rtl/rank_window_ctrl.sv | 147 ++++++++++++++
 tb/tb_rank_window_ctrl.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rank_window_ctrl_if.sv
// Handshake and status bundle between the raster pixel source, the window
// sequencer and the downstream rank-order sorter.
//
// Signals:
//   pix_valid  : source has a pixel this cycle
//   pix_sof    : current pixel is the first of a frame
//   pix_ready  : sequencer accepts the pixel this cycle
//   shift_en   : advance window shift registers and line buffers
//   win_valid  : complete window present at the shift-register outputs
//   win_ready  : sorter consumes the window this cycle
//   win_row    : window centre row (valid with win_valid)
//   win_col    : window centre column (valid with win_valid)
//   frame_done : one-cycle pulse after the last pixel of a frame
//   err_sof    : sticky, sof seen in the middle of a frame
//
// Modports: slave = sequencer side, master = source/sink side.
interface rank_window_ctrl_if #(
    parameter int unsigned WIDTH  = 64,
    parameter int unsigned HEIGHT = 64
) ();
    localparam int unsigned CW = $clog2(WIDTH);
    localparam int unsigned RW = $clog2(HEIGHT);

    logic          pix_valid;
    logic          pix_sof;
    logic          pix_ready;
    logic          shift_en;
    logic          win_valid;
    logic          win_ready;
    logic [RW-1:0] win_row;
    logic [CW-1:0] win_col;
    logic          frame_done;
    logic          err_sof;

    modport slave (
        input  pix_valid,
        input  pix_sof,
        input  win_ready,
        output pix_ready,
        output shift_en,
        output win_valid,
        output win_row,
        output win_col,
        output frame_done,
        output err_sof
    );

    modport master (
        output pix_valid,
        output pix_sof,
        output win_ready,
        input  pix_ready,
        input  shift_en,
        input  win_valid,
        input  win_row,
        input  win_col,
        input  frame_done,
        input  err_sof
    );
endinterface

// File: rtl/rank_window_ctrl.sv
// Sequencer for the N x N window datapath of the masked rank-order filter.
// Tracks the raster position of each accepted pixel, issues one shift enable
// for all window shift registers and line buffers, flags when the window holds
// a complete interior neighbourhood, and stalls the pixel stream while the
// sorter holds off a pending window.
//
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous reset, active high
//   bus : rank_window_ctrl_if.slave (pixel handshake, window handshake, status)
module rank_window_ctrl #(
    parameter int unsigned WIDTH  = 64,
    parameter int unsigned HEIGHT = 64,
    parameter int unsigned N      = 3
) (
    input logic               clk,
    input logic               rst,
    rank_window_ctrl_if.slave bus
);
    localparam int unsigned CW = $clog2(WIDTH);
    localparam int unsigned RW = $clog2(HEIGHT);

    localparam logic [CW-1:0] ColLast  = CW'(WIDTH - 1);
    localparam logic [RW-1:0] RowLast  = RW'(HEIGHT - 1);
    localparam logic [CW-1:0] ColFirst = CW'(N - 1);
    localparam logic [RW-1:0] RowFirst = RW'(N - 1);
    localparam logic [CW-1:0] ColHalf  = CW'((N - 1) / 2);
    localparam logic [RW-1:0] RowHalf  = RW'((N - 1) / 2);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e        state_q, state_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic          win_valid_q, win_valid_d;
    logic [RW-1:0] win_row_q, win_row_d;
    logic [CW-1:0] win_col_q, win_col_d;
    logic          err_q, err_d;

    logic          pix_ready;
    logic          acc;
    logic          shift_en;
    logic [RW-1:0] pix_row;
    logic [CW-1:0] pix_col;
    logic          win_complete;

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        win_valid_d = win_valid_q;
        win_row_d   = win_row_q;
        win_col_d   = win_col_q;
        err_d       = err_q;

        // A window the sorter has not taken blocks everything upstream.
        pix_ready = (state_q != StDone) && !(win_valid_q && !bus.win_ready);
        acc       = bus.pix_valid && pix_ready;
        // Pre-sof pixels in idle are accepted but never enter the datapath.
        shift_en  = acc && ((state_q == StRun) || bus.pix_sof);

        // A sof pixel always lands at (0,0), also when it resyncs a running frame.
        pix_row = bus.pix_sof ? '0 : row_q;
        pix_col = bus.pix_sof ? '0 : col_q;

        case (state_q)
            StIdle: begin
                if (acc && bus.pix_sof) begin
                    state_d = StRun;
                    row_d   = '0;
                    col_d   = CW'(1);
                end
            end
            StRun: begin
                if (acc) begin
                    if (bus.pix_sof) begin
                        err_d = 1'b1;
                        row_d = '0;
                        col_d = CW'(1);
                    end else if (col_q == ColLast) begin
                        col_d = '0;
                        if (row_q == RowLast) begin
                            state_d = StDone;
                            row_d   = '0;
                        end else begin
                            row_d = row_q + RW'(1);
                        end
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                row_d   = '0;
                col_d   = '0;
            end
        endcase

        win_complete = shift_en && (pix_row >= RowFirst) && (pix_col >= ColFirst);

        // A completing accept wins over consumption so back-to-back windows
        // flow without a bubble.
        if (win_complete) begin
            win_valid_d = 1'b1;
            win_row_d   = pix_row - RowHalf;
            win_col_d   = pix_col - ColHalf;
        end else if (bus.win_ready) begin
            win_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            row_q       <= '0;
            col_q       <= '0;
            win_valid_q <= 1'b0;
            win_row_q   <= '0;
            win_col_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            win_valid_q <= win_valid_d;
            win_row_q   <= win_row_d;
            win_col_q   <= win_col_d;
            err_q       <= err_d;
        end
    end

    assign bus.pix_ready  = pix_ready;
    assign bus.shift_en   = shift_en;
    assign bus.win_valid  = win_valid_q;
    assign bus.win_row    = win_row_q;
    assign bus.win_col    = win_col_q;
    assign bus.frame_done = (state_q == StDone);
    assign bus.err_sof    = err_q;
endmodule

// File: tb/tb_rank_window_ctrl.sv
// Self-checking bench for rank_window_ctrl with a 5 x 4 frame and 3 x 3 window.
module tb_rank_window_ctrl;
    localparam int W  = 5;
    localparam int H  = 4;
    localparam int NN = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rank_window_ctrl_if #(.WIDTH(W), .HEIGHT(H)) bus ();

    rank_window_ctrl #(.WIDTH(W), .HEIGHT(H), .N(NN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: frame position as a linear pixel index.
    bit m_run, m_done, m_wv, m_err;
    int m_pos, m_wr, m_wc;

    // Outputs sampled in the most recent cycle.
    bit s_ready, s_shift, s_wv, s_fd, s_err;
    int s_row, s_col;

    // Per-stream statistics.
    int n_shift, n_fd, first_win_at, held;
    int cen_q[$];
    int exp_cen[6];

    typedef struct {
        bit v, s, wr;
        bit ready, shift, wv, fd, err;
    } vec_t;
    vec_t tbl[8];

    function automatic void chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endfunction

    function automatic void model_reset();
        m_run = 0; m_done = 0; m_wv = 0; m_err = 0;
        m_pos = 0; m_wr = 0; m_wc = 0;
    endfunction

    // One clock cycle: drive, sample at negedge, compare with model, advance.
    task automatic cycle(input bit v, input bit s, input bit wr);
        bit e_ready, acc, e_shift;
        int p, r, c;
        bus.pix_valid = v;
        bus.pix_sof   = s;
        bus.win_ready = wr;
        @(negedge clk);
        s_ready = bus.pix_ready;
        s_shift = bus.shift_en;
        s_wv    = bus.win_valid;
        s_fd    = bus.frame_done;
        s_err   = bus.err_sof;
        s_row   = int'(bus.win_row);
        s_col   = int'(bus.win_col);

        e_ready = !m_done && !(m_wv && !wr);
        acc     = v && e_ready;
        e_shift = acc && (m_run || s);
        chk("pix_ready", s_ready, e_ready);
        chk("shift_en", s_shift, e_shift);
        chk("win_valid", s_wv, m_wv);
        if (m_wv) begin
            chk("win_row", s_row, m_wr);
            chk("win_col", s_col, m_wc);
        end
        chk("frame_done", s_fd, m_done);
        chk("err_sof", s_err, m_err);

        if (s_wv && first_win_at < 0) first_win_at = n_shift;
        if (s_wv && wr) cen_q.push_back(s_row * 10 + s_col);
        if (s_shift) n_shift++;
        if (s_fd) n_fd++;

        p = s ? 0 : m_pos;
        r = p / W;
        c = p % W;
        if (e_shift && r >= NN - 1 && c >= NN - 1) begin
            m_wv = 1;
            m_wr = r - (NN - 1) / 2;
            m_wc = c - (NN - 1) / 2;
        end else if (wr) begin
            m_wv = 0;
        end
        if (m_done) begin
            m_done = 0;
        end else if (acc) begin
            if (s) begin
                if (m_run) m_err = 1;
                m_run = 1;
                m_pos = 1;
            end else if (m_run) begin
                if (m_pos == W * H - 1) begin
                    m_run  = 0;
                    m_done = 1;
                    m_pos  = 0;
                end else begin
                    m_pos++;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.pix_valid = 0;
        bus.pix_sof   = 0;
        bus.win_ready = 1;
        rst = 1;
        #1;
        chk("rst_win_valid", bus.win_valid, 0);
        chk("rst_win_row", int'(bus.win_row), 0);
        chk("rst_win_col", int'(bus.win_col), 0);
        chk("rst_frame_done", bus.frame_done, 0);
        chk("rst_err_sof", bus.err_sof, 0);
        chk("rst_shift_en", bus.shift_en, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 0;
        model_reset();
        #1;
        chk("rst_release_ready", bus.pix_ready, 1);
    endtask

    // Feed pre garbage pixels, then npix frame pixels (sof on the first and
    // on index sof2), optionally stalling the first window for 3 cycles.
    task automatic run_stream(input int pre, input int npix, input int sof2, input bit bp,
                              input int abort_at);
        int  idx     = 0;
        int  garbage = pre;
        int  hold    = 0;
        bit  bp_used = 0;
        bit  wr, sf;
        n_shift = 0; n_fd = 0; first_win_at = -1; held = 0;
        cen_q.delete();
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (garbage == 0 && idx >= npix) break;
            if (abort_at > 0 && idx >= abort_at) break;
            if (bp && !bp_used && bus.win_valid) begin
                hold    = 3;
                bp_used = 1;
            end
            wr = (hold == 0);
            sf = (garbage == 0) && (idx == 0 || idx == sof2);
            cycle(1'b1, sf, wr);
            if (!wr && !s_ready && !s_shift && s_wv && s_row == 1 && s_col == 1) held++;
            if (s_ready) begin
                if (garbage > 0) garbage--;
                else idx++;
            end
            if (hold > 0) hold--;
        end
        if (abort_at > 0) return;
        chk("stream_accepts", idx, npix);
        for (int k = 0; k < 6; k++) cycle(1'b0, 1'b0, 1'b1);
    endtask

    task automatic check_frame(input string tag, input int exp_shift, input int exp_first);
        chk({tag, "_windows"}, cen_q.size(), 6);
        chk({tag, "_frame_done"}, n_fd, 1);
        chk({tag, "_shifts"}, n_shift, exp_shift);
        chk({tag, "_first_win"}, first_win_at, exp_first);
        for (int i = 0; i < 6; i++)
            if (i < cen_q.size()) chk($sformatf("%s_centre%0d", tag, i), cen_q[i], exp_cen[i]);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        exp_cen = '{11, 12, 13, 21, 22, 23};
        //            v  s  wr ready shift wv fd err
        tbl[0] = '{0, 0, 1, 1, 0, 0, 0, 0};  // idle
        tbl[1] = '{1, 0, 1, 1, 0, 0, 0, 0};  // pre-sof pixel dropped
        tbl[2] = '{1, 1, 1, 1, 1, 0, 0, 0};  // sof -> (0,0)
        tbl[3] = '{1, 0, 1, 1, 1, 0, 0, 0};  // (0,1)
        tbl[4] = '{0, 0, 1, 1, 0, 0, 0, 0};  // gap
        tbl[5] = '{1, 1, 0, 1, 1, 0, 0, 0};  // resync sof mid-frame
        tbl[6] = '{0, 0, 1, 1, 0, 0, 0, 1};  // err now sticky
        tbl[7] = '{1, 0, 1, 1, 1, 0, 0, 1};

        rst = 1;
        bus.pix_valid = 0;
        bus.pix_sof   = 0;
        bus.win_ready = 1;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        for (int i = 0; i < 8; i++) begin
            cycle(tbl[i].v, tbl[i].s, tbl[i].wr);
            chk($sformatf("tbl%0d_ready", i), s_ready, tbl[i].ready);
            chk($sformatf("tbl%0d_shift", i), s_shift, tbl[i].shift);
            chk($sformatf("tbl%0d_wv", i), s_wv, tbl[i].wv);
            chk($sformatf("tbl%0d_fd", i), s_fd, tbl[i].fd);
            chk($sformatf("tbl%0d_err", i), s_err, tbl[i].err);
        end

        // Reset mid-stream with err_sof set.
        do_reset();

        run_stream(0, 20, -1, 1'b0, 0);
        check_frame("clean", 20, 13);

        run_stream(0, 20, -1, 1'b1, 0);
        check_frame("bp", 20, 13);
        chk("bp_held_cycles", held, 3);

        run_stream(3, 20, -1, 1'b0, 0);
        check_frame("garbage", 20, 13);

        run_stream(0, 27, 7, 1'b0, 0);
        check_frame("midsof", 27, 20);
        chk("midsof_err", s_err, 1);

        run_stream(0, 20, -1, 1'b0, 10);
        do_reset();
        run_stream(0, 20, -1, 1'b0, 0);
        check_frame("after_rst", 20, 13);
        chk("after_rst_err", s_err, 0);

        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end else begin
                cycle($urandom_range(0, 9) < 8,
                      m_run ? ($urandom_range(0, 59) == 0) : ($urandom_range(0, 3) == 0),
                      $urandom_range(0, 9) < 7);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
